// File: rtl/timer_pkg.sv
// Shared constants for the memory-mapped countdown timer: register offsets,
// CTRL bit layout, mode codes and FSM state encoding.
package timer_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;
  localparam logic [1:0] ADDR_RSVD   = 2'd3;

  localparam int EN_BIT   = 0;
  localparam int MODE_LSB = 1;
  localparam int IM_BIT   = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_t;

endpackage

// File: rtl/timer_dev.sv
// Countdown timer responder on the core load/store bus: CTRL/PRESET/COUNT
// registers, one-shot or auto-reload operation and a maskable level IRQ.
module timer_dev
  import timer_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Addr,
  input  logic        WE,
  input  logic [31:0] WD,
  output logic [31:0] RD,
  output logic        IRQ
);

  state_t             state_q;
  state_t             state_d;
  logic               ctrl_en;
  logic [1:0]         ctrl_mode;
  logic               ctrl_im;
  logic [CNT_W-1:0]   preset;
  logic [CNT_W-1:0]   count;
  logic               irq_flag;

  logic               do_load;
  logic               do_dec;
  logic               set_irq;
  logic               clr_irq;
  logic               clr_en;
  logic               wr_ctrl;
  logic               wr_preset;
  logic               unused_addr;

  assign unused_addr = ^{Addr[31:4], Addr[1:0]};
  assign wr_ctrl     = WE && (Addr[3:2] == ADDR_CTRL);
  assign wr_preset   = WE && (Addr[3:2] == ADDR_PRESET);

  always_comb begin
    state_d = state_q;
    do_load = 1'b0;
    do_dec  = 1'b0;
    set_irq = 1'b0;
    clr_irq = 1'b0;
    clr_en  = 1'b0;
    case (state_q)
      IDLE: if (ctrl_en) state_d = LOAD;
      LOAD: begin
        do_load = 1'b1;
        state_d = CNT;
      end
      CNT: begin
        if (!ctrl_en) begin
          state_d = IDLE;
        end else if (count == '0) begin
          state_d = INT;
          set_irq = 1'b1;
        end else begin
          do_dec = 1'b1;
        end
      end
      INT: begin
        // Only mode 01 reloads; 10 and 11 fall back to one-shot.
        if (ctrl_mode == MODE_RELOAD) begin
          clr_irq = 1'b1;
          state_d = LOAD;
        end else begin
          clr_en  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      ctrl_en   <= 1'b0;
      ctrl_mode <= MODE_ONESHOT;
      ctrl_im   <= 1'b0;
      preset    <= '0;
      count     <= '0;
      irq_flag  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (do_load) begin
        count <= preset;
      end else if (do_dec) begin
        count <= count - CNT_W'(1);
      end
      if (wr_preset) preset <= CNT_W'(WD);
      // A bus write to CTRL wins over the FSM dropping En on one-shot expiry.
      if (wr_ctrl) begin
        ctrl_en   <= WD[EN_BIT];
        ctrl_mode <= WD[MODE_LSB +: 2];
        ctrl_im   <= WD[IM_BIT];
      end else if (clr_en) begin
        ctrl_en <= 1'b0;
      end
      if (wr_ctrl || clr_irq) begin
        irq_flag <= 1'b0;
      end else if (set_irq) begin
        irq_flag <= 1'b1;
      end
    end
  end

  always_comb begin
    RD = '0;
    case (Addr[3:2])
      ADDR_CTRL: begin
        RD[EN_BIT]          = ctrl_en;
        RD[MODE_LSB +: 2]   = ctrl_mode;
        RD[IM_BIT]          = ctrl_im;
      end
      ADDR_PRESET: RD = 32'(preset);
      ADDR_COUNT:  RD = 32'(count);
      ADDR_RSVD:   RD = '0;
      default:     RD = '0;
    endcase
  end

  assign IRQ = irq_flag & ctrl_im;

endmodule

// File: tb/tb_timer_dev.sv
// Bench for timer_dev: directed scenarios with literal expectations plus
// randomized bus traffic compared every cycle against a run-position model.
module tb_timer_dev;

  logic        clk;
  logic        reset;
  logic [31:0] Addr;
  logic        WE;
  logic [31:0] WD;
  logic [31:0] RD;
  logic        IRQ;

  int total = 0;
  int bad   = 0;
  bit chk_on = 0;

  timer_dev #(.CNT_W(32)) dut (
    .clk  (clk),
    .reset(reset),
    .Addr (Addr),
    .WE   (WE),
    .WD   (WD),
    .RD   (RD),
    .IRQ  (IRQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: a run starts when En is seen while idle; m_t is the number of
  // edges elapsed in the current run. Edge 1 loads N=PRESET, edges 2..N+1
  // count down, edge N+2 raises the flag, edge N+3 ends or restarts the run.
  bit          m_en, m_im, m_flag, m_idle;
  logic [1:0]  m_mode;
  logic [31:0] m_preset, m_count;
  longint      m_n, m_t;

  function automatic void model_step();
    bit wc, wp, clr_en, set_f, clr_f;
    longint e;
    clr_en = 0; set_f = 0; clr_f = 0;
    if (!reset) begin
      m_en = 0; m_im = 0; m_mode = 2'b00; m_preset = 0; m_count = 0;
      m_flag = 0; m_idle = 1; m_t = 0; m_n = 0;
      return;
    end
    wc = WE && (Addr[3:2] == 2'd0);
    wp = WE && (Addr[3:2] == 2'd1);
    if (m_idle) begin
      if (m_en) begin m_idle = 0; m_t = 0; end
    end else begin
      e = m_t + 1;
      m_t = e;
      if (e == 1) begin
        m_n = longint'(m_preset);
        m_count = m_preset;
      end else if (e <= m_n + 2) begin
        if (!m_en) m_idle = 1;
        else if (e == m_n + 2) set_f = 1;
        else m_count = 32'(m_n - (e - 1));
      end else begin
        if (m_mode == 2'b01) begin clr_f = 1; m_t = 0; end
        else begin clr_en = 1; m_idle = 1; end
      end
    end
    if (wp) m_preset = WD;
    if (wc) begin
      m_en = WD[0]; m_mode = WD[2:1]; m_im = WD[3]; m_flag = 0;
    end else begin
      if (clr_en) m_en = 0;
      if (clr_f) m_flag = 0;
      else if (set_f) m_flag = 1;
    end
  endfunction

  function automatic logic [31:0] model_read(input logic [1:0] a);
    case (a)
      2'd0: return {28'd0, m_im, m_mode, m_en};
      2'd1: return m_preset;
      2'd2: return m_count;
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk) model_step();

  always @(negedge clk) begin
    if (chk_on) begin
      total++;
      if (RD !== model_read(Addr[3:2])) begin
        bad++;
        $display("FAIL model_rd addr=%0d got=%h exp=%h t=%0t", Addr[3:2], RD, model_read(Addr[3:2]), $time);
      end
      total++;
      if (IRQ !== (m_flag & m_im)) begin
        bad++;
        $display("FAIL model_irq got=%b exp=%b t=%0t", IRQ, m_flag & m_im, $time);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    Addr = {28'd0, a, 2'b00};
    WD = d;
    WE = 1'b1;
    tick();
    WE = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
    Addr = {28'd0, a, 2'b00};
    WE = 1'b0;
    #1;
    chk(name, RD, exp);
  endtask

  task automatic irq_chk(input string name, input logic exp);
    #1;
    chk(name, {31'd0, IRQ}, {31'd0, exp});
  endtask

  task automatic settle();
    wr(2'd0, 32'h0);
    repeat (6) tick();
  endtask

  initial begin
    logic [31:0] r;
    reset = 1'b0; WE = 1'b1; WD = 32'hFFFF_FFFF; Addr = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1; WE = 1'b0;
    chk_on = 1;
    rd_chk("rst_ctrl", 2'd0, 32'h0);
    rd_chk("rst_preset", 2'd1, 32'h0);
    rd_chk("rst_count", 2'd2, 32'h0);
    irq_chk("rst_irq", 1'b0);

    // One-shot, PRESET=3
    wr(2'd1, 32'd3);
    wr(2'd0, 32'h9);
    Addr = 32'h8;
    tick();
    for (int k = 2; k <= 5; k++) begin
      tick();
      rd_chk("os_count", 2'd2, 32'(5 - k));
      if (k == 5) irq_chk("os_irq_e5", 1'b0);
    end
    tick();
    irq_chk("os_irq_e6", 1'b1);
    tick();
    tick();
    irq_chk("os_irq_hold", 1'b1);
    rd_chk("os_ctrl", 2'd0, 32'h8);
    wr(2'd0, 32'h8);
    irq_chk("os_irq_clr", 1'b0);
    settle();

    // Auto-reload, PRESET=2: one-cycle pulse every 5 edges
    wr(2'd1, 32'd2);
    wr(2'd0, 32'hB);
    Addr = 32'h8;
    for (int k = 1; k <= 16; k++) begin
      tick();
      irq_chk("ar_irq", (k % 5) == 0);
      if ((k % 5) == 2) rd_chk("ar_reload", 2'd2, 32'd2);
    end
    settle();

    // Pause at COUNT=5, then restart from LOAD with IM=0
    wr(2'd1, 32'd8);
    wr(2'd0, 32'h1);
    Addr = 32'h8;
    repeat (4) tick();
    wr(2'd0, 32'h0);
    for (int k = 0; k < 10; k++) begin
      rd_chk("pause_hold", 2'd2, 32'd5);
      tick();
    end
    wr(2'd0, 32'h1);
    Addr = 32'h8;
    tick();
    tick();
    rd_chk("resume_reload", 2'd2, 32'd8);
    for (int k = 3; k <= 13; k++) begin
      tick();
      if (k == 10) rd_chk("resume_zero", 2'd2, 32'd0);
      irq_chk("masked_irq", 1'b0);
    end
    rd_chk("resume_ctrl", 2'd0, 32'h0);
    settle();

    // Ignored writes, reserved read, PRESET write mid-count
    wr(2'd1, 32'd6);
    wr(2'd0, 32'h1);
    tick();
    tick();
    wr(2'd2, 32'h55);
    wr(2'd3, 32'hFF);
    rd_chk("ign_count", 2'd2, 32'd4);
    rd_chk("rsvd_read", 2'd3, 32'd0);
    wr(2'd1, 32'd2);
    rd_chk("preset_mid", 2'd2, 32'd3);
    tick();
    rd_chk("preset_mid2", 2'd2, 32'd2);
    settle();

    // CTRL write in the same cycle as one-shot INT keeps En
    wr(2'd1, 32'd1);
    wr(2'd0, 32'h9);
    repeat (4) tick();
    irq_chk("int_pre", 1'b1);
    wr(2'd0, 32'h9);
    rd_chk("int_ctrl_win", 2'd0, 32'h9);
    irq_chk("int_wr_clr", 1'b0);
    settle();

    // Reset pulse at COUNT=4
    wr(2'd1, 32'd9);
    wr(2'd0, 32'h1);
    Addr = 32'h8;
    repeat (7) tick();
    rd_chk("mid_pre", 2'd2, 32'd4);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    rd_chk("mid_ctrl", 2'd0, 32'h0);
    rd_chk("mid_preset", 2'd1, 32'h0);
    rd_chk("mid_count", 2'd2, 32'h0);
    irq_chk("mid_irq", 1'b0);
    repeat (3) tick();
    rd_chk("mid_stay", 2'd2, 32'h0);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      r = $urandom();
      Addr = $urandom();
      WE = 1'b0;
      if ($urandom_range(0, 499) == 0) begin
        reset = 1'b0;
      end else begin
        reset = 1'b1;
        if ($urandom_range(0, 7) == 0) begin
          WE = 1'b1;
          if (Addr[3:2] == 2'd1) begin
            WD = $urandom_range(0, 12);
          end else begin
            r[0] = ($urandom_range(0, 3) != 0);
            WD = r;
          end
        end
      end
      tick();
    end
    reset = 1'b1;
    WE = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
